// File: rtl/up_counter_4bit_pkg.sv
// Purpose: shared constants for the counter family.
// Latency: n/a (constants only).
// Backpressure: n/a.
package up_counter_4bit_pkg;

    // Default counter width used when an instance does not override it.
    localparam int COUNTER_W_DEFAULT = 4;

endpackage : up_counter_4bit_pkg

// File: rtl/up_counter_4bit.sv
// Purpose: binary up-counter with parallel load, count enable and terminal-count flag.
// Latency: one cycle from load/enable to out; tc is combinational.
// Backpressure: none; load and enable are acted on at every rising clk edge.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset, clears out
//   enable   increment on the edge when 1
//   load     capture data_in on the edge when 1 (beats enable)
//   data_in  parallel load value, ignored when load = 0
//   out      current count, straight from the register
//   tc       enable & (out == all ones); lets a following stage count on our wrap
module up_counter_4bit
    import up_counter_4bit_pkg::*;
#(
    parameter int width = COUNTER_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             load,
    input  logic [width-1:0] data_in,
    output logic [width-1:0] out,
    output logic             tc
);

    logic [width-1:0] cnt_nxt;

    // Load wins over enable; data_in only reaches the register when load = 1,
    // so an undriven data_in cannot leak into the count.
    always_comb begin
        cnt_nxt = out;
        if (load) begin
            cnt_nxt = data_in;
        end else if (enable) begin
            // Carry-out discarded: all ones wraps to zero.
            cnt_nxt = out + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= cnt_nxt;
        end
    end

    // Gated by enable only, not by load: flags the cycle that would wrap.
    assign tc = enable & (&out);

endmodule : up_counter_4bit

// File: tb/tb_up_counter_4bit.sv
module tb_up_counter_4bit;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         enable = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] out;
    logic         tc;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference state: plain integer count, known only once reset or load has happened.
    int m_cnt   = 0;
    bit m_valid = 1'b0;

    up_counter_4bit #(.width(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .load    (load),
        .data_in (data_in),
        .out     (out),
        .tc      (tc)
    );

    always #5 clk = ~clk;

    // Reference model: reset, then load, then increment modulo 2^W, else hold.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt   = 0;
            m_valid = 1'b1;
        end else if (load) begin
            m_cnt   = int'(data_in);
            m_valid = 1'b1;
        end else if (enable) begin
            m_cnt = (m_cnt + 1) % MOD;
        end
    end

    // Every-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            n_vec++;
            if (int'(out) != m_cnt || tc !== (enable && m_cnt == MOD - 1)) begin
                n_miss++;
                $display("FAIL model_cmp t=%0t: out=%0d tc=%0b, required out=%0d tc=%0b",
                         $time, out, tc, m_cnt, (enable && m_cnt == MOD - 1));
            end
        end
    end

    // Apply inputs just after the falling edge; they are captured at the next rising edge.
    task automatic drive(input logic r, input logic l, input logic e, input logic [W-1:0] d);
        @(negedge clk);
        #1;
        rst_n   = r;
        load    = l;
        enable  = e;
        data_in = d;
    endtask

    // Hand-computed expectation, checked just after the next rising edge.
    task automatic expect_lit(input string name, input int exp_out, input logic exp_tc);
        @(posedge clk);
        #1;
        n_vec++;
        if (int'(out) != exp_out || tc !== exp_tc) begin
            n_miss++;
            $display("FAIL %s: out=%0d tc=%0b, required out=%0d tc=%0b",
                     name, out, tc, exp_out, exp_tc);
        end
    endtask

    initial begin
        logic r, l, e;
        logic [W-1:0] d;

        // Reset from an arbitrary prior count, then release and count.
        drive(1, 1, 1, 4'd9);  expect_lit("preload", 9, 1'b0);
        drive(0, 0, 1, 4'd5);  expect_lit("reset", 0, 1'b0);
        drive(1, 0, 1, 4'd0);  expect_lit("cnt1", 1, 1'b0);
        expect_lit("cnt2", 2, 1'b0);
        expect_lit("cnt3", 3, 1'b0);

        // Enable gating.
        drive(1, 0, 0, 4'd0);  expect_lit("hold3", 3, 1'b0);
        drive(1, 0, 1, 4'd0);  expect_lit("cnt4", 4, 1'b0);
        expect_lit("cnt5", 5, 1'b0);

        // Load beats enable.
        drive(1, 1, 1, 4'b1011); expect_lit("load11", 11, 1'b0);
        drive(1, 0, 1, 4'd0);    expect_lit("cnt12", 12, 1'b0);

        // Wrap and tc.
        drive(1, 1, 1, 4'b1111); expect_lit("tc_at15", 15, 1'b1);
        drive(1, 0, 1, 4'd0);    expect_lit("wrap0", 0, 1'b0);
        drive(1, 1, 0, 4'b1111); expect_lit("load15_dis", 15, 1'b0);
        drive(1, 0, 0, 4'd0);    expect_lit("hold15_notc", 15, 1'b0);

        // Load while disabled, then resume counting.
        drive(1, 1, 0, 4'b0000); expect_lit("load0_dis", 0, 1'b0);
        drive(1, 0, 0, 4'd7);    expect_lit("hold0a", 0, 1'b0);
        expect_lit("hold0b", 0, 1'b0);
        drive(1, 0, 1, 4'd7);    expect_lit("resume1", 1, 1'b0);
        expect_lit("resume2", 2, 1'b0);

        // Reset held for five edges while counting.
        drive(0, 0, 1, 4'b0011);
        for (int i = 0; i < 5; i++) expect_lit("reset_hold", 0, 1'b0);
        drive(1, 0, 1, 4'b0011); expect_lit("post_rst1", 1, 1'b0);
        expect_lit("post_rst2", 2, 1'b0);

        // Reset beats load.
        drive(0, 1, 1, 4'b0011); expect_lit("rst_over_load", 0, 1'b0);

        // Randomized traffic, checked by the every-cycle model compare.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 19) != 0);
            l = ($urandom_range(0, 3) == 0);
            e = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 3) == 0) ? 4'hF : W'($urandom_range(0, MOD - 1));
            drive(r, l, e, d);
        end

        drive(1, 0, 0, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_up_counter_4bit
